// File: rtl/d_ff_pkg.sv
// Shared definitions for the debounced D-input path: FSM state encoding and
// the default synchroniser depth.
package d_ff_pkg;

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_e;

  localparam int DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_ff_chain.sv
// Multi-flop synchroniser for a single asynchronous level; q_sync is the last stage.
module sync_ff_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_async,
  output logic q_sync
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d_async};
    end
  end

  assign q_sync = chain_q[STAGES-1];

endmodule

// File: rtl/d_input_debouncer.sv
// Synchronises and debounces a raw button level into a clean D, with rise/fall
// strobes and a saturating count of rejected bounces.
module d_input_debouncer
  import d_ff_pkg::*;
#(
  parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES,
  parameter int STABLE_CYCLES = 4,
  parameter int BOUNCE_W      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn_in,
  output logic                D,
  output logic                rise_pulse,
  output logic                fall_pulse,
  output logic [BOUNCE_W-1:0] bounce_cnt
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(STABLE_CYCLES);

  logic                btn_sync;
  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic                d_q;
  logic                rise_q;
  logic                fall_q;
  logic [BOUNCE_W-1:0] bounce_q;
  logic [BOUNCE_W-1:0] bounce_d;

  sync_ff_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .d_async (btn_in),
    .q_sync  (btn_sync)
  );

  // Candidate next counter value and saturating bounce increment.
  assign cnt_d    = cnt_q + 1'b1;
  assign bounce_d = (bounce_q == '1) ? bounce_q : bounce_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE_LO;
      cnt_q    <= '0;
      d_q      <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      bounce_q <= '0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state_q)
        IDLE_LO: begin
          if (btn_sync) begin
            if (STABLE_CYCLES == 1) begin
              state_q <= IDLE_HI;
              d_q     <= 1'b1;
              rise_q  <= 1'b1;
            end else begin
              state_q <= WAIT_HI;
              cnt_q   <= CNT_W'(1);
            end
          end
        end
        WAIT_HI: begin
          if (btn_sync) begin
            if (cnt_d == CNT_TARGET) begin
              state_q <= IDLE_HI;
              d_q     <= 1'b1;
              rise_q  <= 1'b1;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_d;
            end
          end else begin
            state_q  <= IDLE_LO;
            cnt_q    <= '0;
            bounce_q <= bounce_d;
          end
        end
        IDLE_HI: begin
          if (!btn_sync) begin
            if (STABLE_CYCLES == 1) begin
              state_q <= IDLE_LO;
              d_q     <= 1'b0;
              fall_q  <= 1'b1;
            end else begin
              state_q <= WAIT_LO;
              cnt_q   <= CNT_W'(1);
            end
          end
        end
        default: begin  // WAIT_LO
          if (!btn_sync) begin
            if (cnt_d == CNT_TARGET) begin
              state_q <= IDLE_LO;
              d_q     <= 1'b0;
              fall_q  <= 1'b1;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_d;
            end
          end else begin
            state_q  <= IDLE_HI;
            cnt_q    <= '0;
            bounce_q <= bounce_d;
          end
        end
      endcase
    end
  end

  assign D          = d_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign bounce_cnt = bounce_q;

endmodule

// File: tb/tb_d_input_debouncer.sv
// Directed bench for d_input_debouncer with SYNC_STAGES=2, STABLE_CYCLES=4.
module tb_d_input_debouncer;

  logic       clk;
  logic       rst;
  logic       btn_in;
  logic       D;
  logic       rise_pulse;
  logic       fall_pulse;
  logic [7:0] bounce_cnt;

  int checks;
  int failures;
  bit mon_en;
  logic d_prev, rise_prev, fall_prev, rst_prev;

  d_input_debouncer #(
    .SYNC_STAGES   (2),
    .STABLE_CYCLES (4),
    .BOUNCE_W      (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_in     (btn_in),
    .D          (D),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .bounce_cnt (bounce_cnt)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Wait for one rising edge, then sample 1 ns later.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Continuous protocol checks, sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_en && !rst && !rst_prev) begin
      checks++;
      if (rise_pulse && fall_pulse) begin
        failures++;
        $display("FAIL both_pulses t=%0t rise=%b fall=%b required not both", $time, rise_pulse, fall_pulse);
      end
      checks++;
      if ((rise_pulse && rise_prev) || (fall_pulse && fall_prev)) begin
        failures++;
        $display("FAIL pulse_width t=%0t rise=%b/%b fall=%b/%b required width 1", $time, rise_prev, rise_pulse, fall_prev, fall_pulse);
      end
      checks++;
      if ((D !== d_prev) !== (rise_pulse || fall_pulse) ||
          (rise_pulse && D !== 1'b1) || (fall_pulse && D !== 1'b0)) begin
        failures++;
        $display("FAIL d_vs_pulse t=%0t D=%b->%b rise=%b fall=%b required matching pulse", $time, d_prev, D, rise_pulse, fall_pulse);
      end
    end
    d_prev    = D;
    rise_prev = rise_pulse;
    fall_prev = fall_pulse;
    rst_prev  = rst;
  end

  task automatic test_reset();
    rst    = 1'b1;
    btn_in = 1'b1;
    for (int e = 0; e < 2; e++) begin
      tick(1);
      checks++;
      if (D !== 1'b0 || rise_pulse !== 1'b0 || fall_pulse !== 1'b0 || bounce_cnt !== 8'd0) begin
        failures++;
        $display("FAIL reset edge%0d D=%b rise=%b fall=%b bounce=%0d required 0/0/0/0", e, D, rise_pulse, fall_pulse, bounce_cnt);
      end
    end
    btn_in = 1'b0;
    rst    = 1'b0;
    tick(4);
    mon_en = 1'b1;
    $display("test_reset done");
  endtask

  // Raw step before edge k; ticks 1..n observe edges k..k+n-1. Acceptance at edge k+5.
  task automatic test_clean_rise();
    btn_in = 1'b1;
    tick(5);
    checks++;
    if (D !== 1'b0 || rise_pulse !== 1'b0) begin
      failures++;
      $display("FAIL rise_early D=%b rise=%b required D=0 rise=0 at edge k+4", D, rise_pulse);
    end
    tick(1);
    checks++;
    if (D !== 1'b1 || rise_pulse !== 1'b1 || fall_pulse !== 1'b0) begin
      failures++;
      $display("FAIL rise_accept D=%b rise=%b fall=%b required 1/1/0 at edge k+5", D, rise_pulse, fall_pulse);
    end
    tick(1);
    checks++;
    if (D !== 1'b1 || rise_pulse !== 1'b0) begin
      failures++;
      $display("FAIL rise_after D=%b rise=%b required D=1 rise=0", D, rise_pulse);
    end
    tick(3);
    $display("test_clean_rise done");
  endtask

  task automatic test_clean_fall();
    btn_in = 1'b0;
    tick(5);
    checks++;
    if (D !== 1'b1 || fall_pulse !== 1'b0) begin
      failures++;
      $display("FAIL fall_early D=%b fall=%b required D=1 fall=0 at edge k+4", D, fall_pulse);
    end
    tick(1);
    checks++;
    if (D !== 1'b0 || fall_pulse !== 1'b1 || rise_pulse !== 1'b0) begin
      failures++;
      $display("FAIL fall_accept D=%b fall=%b rise=%b required 0/1/0 at edge k+5", D, fall_pulse, rise_pulse);
    end
    tick(1);
    checks++;
    if (D !== 1'b0 || fall_pulse !== 1'b0 || bounce_cnt !== 8'd0) begin
      failures++;
      $display("FAIL fall_after D=%b fall=%b bounce=%0d required 0/0/0", D, fall_pulse, bounce_cnt);
    end
    tick(3);
    $display("test_clean_fall done");
  endtask

  // Three synchronised high samples then low: counter reaches 3, aborts.
  task automatic test_bounce();
    bit saw_rise;
    saw_rise = 1'b0;
    btn_in = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(1); saw_rise |= rise_pulse; end
    btn_in = 1'b0;
    for (int i = 0; i < 5; i++) begin tick(1); saw_rise |= rise_pulse; end
    checks++;
    if (D !== 1'b0 || saw_rise !== 1'b0 || bounce_cnt !== 8'd1) begin
      failures++;
      $display("FAIL bounce_abort D=%b saw_rise=%b bounce=%0d required 0/0/1", D, saw_rise, bounce_cnt);
    end
    btn_in = 1'b1;
    tick(5);
    checks++;
    if (D !== 1'b0) begin
      failures++;
      $display("FAIL bounce_reentry_early D=%b required 0 at edge k+4", D);
    end
    tick(1);
    checks++;
    if (D !== 1'b1 || rise_pulse !== 1'b1 || bounce_cnt !== 8'd1) begin
      failures++;
      $display("FAIL bounce_reentry D=%b rise=%b bounce=%0d required 1/1/1", D, rise_pulse, bounce_cnt);
    end
    tick(2);
    $display("test_bounce done");
  endtask

  task automatic test_saturation();
    rst = 1'b1;
    btn_in = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(3);
    for (int i = 1; i <= 300; i++) begin
      btn_in = 1'b1;
      tick(2);
      btn_in = 1'b0;
      tick(4);
      if (i == 254 || i == 255 || i == 300) begin
        checks++;
        if (bounce_cnt !== ((i < 255) ? 8'(i) : 8'd255) || D !== 1'b0) begin
          failures++;
          $display("FAIL saturation burst=%0d bounce=%0d D=%b required %0d/0", i, bounce_cnt, D, (i < 255) ? i : 255);
        end
      end
    end
    tick(5);
    checks++;
    if (bounce_cnt !== 8'd255) begin
      failures++;
      $display("FAIL saturation_hold bounce=%0d required 255", bounce_cnt);
    end
    $display("test_saturation done");
  endtask

  // Counter is 2 after edge k+3; reset at edge k+4; restart accepts at edge k+10.
  task automatic test_reset_mid_wait();
    bit saw_rise;
    saw_rise = 1'b0;
    btn_in = 1'b1;
    tick(4);
    rst = 1'b1;
    tick(1);
    checks++;
    if (D !== 1'b0 || rise_pulse !== 1'b0 || bounce_cnt !== 8'd0) begin
      failures++;
      $display("FAIL mid_wait_reset D=%b rise=%b bounce=%0d required 0/0/0", D, rise_pulse, bounce_cnt);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin tick(1); saw_rise |= rise_pulse | D; end
    checks++;
    if (saw_rise !== 1'b0) begin
      failures++;
      $display("FAIL mid_wait_restart_early D=%b rise_or_D_seen=%b required 0 before edge k+10", D, saw_rise);
    end
    tick(1);
    checks++;
    if (D !== 1'b1 || rise_pulse !== 1'b1 || bounce_cnt !== 8'd0) begin
      failures++;
      $display("FAIL mid_wait_restart D=%b rise=%b bounce=%0d required 1/1/0", D, rise_pulse, bounce_cnt);
    end
    tick(2);
    $display("test_reset_mid_wait done");
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    mon_en   = 1'b0;
    rst      = 1'b1;
    btn_in   = 1'b0;
    test_reset();
    test_clean_rise();
    test_clean_fall();
    test_bounce();
    test_saturation();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
